pipelined_shifter: RTL



---
 rtl/shifter_pkg.sv | 16 +
 rtl/shift_level.sv | 35 +++
 rtl/pipelined_shifter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROL = 2'b11
  } shift_op_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

endpackage

// File: rtl/shift_level.sv
// One combinational mux level of the barrel shifter: shifts by DIST when en=1.
// Build option: SHIFTER_ROTATE_EN adds the wrap-around input for rotate-left;
// without it, rotate-left falls through to the logical-left result.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted
);

  shift_op_t op_e;
  assign op_e = shift_op_t'(op);

  // Select the shifted or pass-through value for this level's distance.
  always_comb begin
    shifted = data;
    if (en) begin
      case (op_e)
        SH_LSR:  shifted = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
        SH_ASR:  shifted = {{DIST{fill}}, data[WIDTH-1:DIST]};
`ifdef SHIFTER_ROTATE_EN
        SH_ROL:  shifted = {data[WIDTH-DIST-1:0], data[WIDTH-1 -: DIST]};
`endif
        default: shifted = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (LSL / LSR / ASR / optional ROL) built from CNT_W
// shift_level instances. PIPELINED=1 registers every level (latency CNT_W);
// PIPELINED=0 uses a single output register (latency 1).
// Build option: SHIFTER_ROTATE_EN enables op 11 as rotate-left.
//
// Handshake: an operand transfers on a rising edge where in_valid && in_ready;
// a result transfers where out_valid && out_ready. The whole pipeline moves
// together: advance = out_ready || !out_valid, and in_ready = advance, so
// in_ready depends only on out_ready and out_valid. Bubbles travel like data.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_W     = $clog2(WIDTH),
  parameter int PIPELINED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  logic             advance;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_zero_q;

  // Inputs and outputs of each mux level.
  logic [WIDTH-1:0] lvl_in   [CNT_W];
  logic [WIDTH-1:0] lvl_out  [CNT_W];
  logic [1:0]       lvl_op   [CNT_W];
  logic [CNT_W-1:0] lvl_cnt  [CNT_W];
  logic             lvl_sign [CNT_W];

  assign advance   = out_ready || !out_valid_q;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;

  for (genvar k = 0; k < CNT_W; k++) begin : g_level
    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_level (
      .data    (lvl_in[k]),
      .en      (lvl_cnt[k][k]),
      .op      (lvl_op[k]),
      .fill    (lvl_sign[k]),
      .shifted (lvl_out[k])
    );
  end

  if (PIPELINED != 0) begin : g_pipe
    // Registers between level k and level k+1; the last level feeds the output register.
    logic [WIDTH-1:0] st_data  [CNT_W-1];
    logic [1:0]       st_op    [CNT_W-1];
    logic [CNT_W-1:0] st_cnt   [CNT_W-1];
    logic             st_sign  [CNT_W-1];
    logic             st_valid [CNT_W-1];

    for (genvar k = 0; k < CNT_W; k++) begin : g_feed
      if (k == 0) begin : g_first
        assign lvl_in[k]   = in_data;
        assign lvl_op[k]   = in_op;
        assign lvl_cnt[k]  = in_cnt;
        assign lvl_sign[k] = in_data[WIDTH-1];
      end else begin : g_rest
        assign lvl_in[k]   = st_data[k-1];
        assign lvl_op[k]   = st_op[k-1];
        assign lvl_cnt[k]  = st_cnt[k-1];
        assign lvl_sign[k] = st_sign[k-1];
      end
    end

    // Advance every stage together; a stall freezes all of them.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < CNT_W-1; i++) begin
          st_data[i]  <= '0;
          st_op[i]    <= '0;
          st_cnt[i]   <= '0;
          st_sign[i]  <= 1'b0;
          st_valid[i] <= 1'b0;
        end
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        out_zero_q  <= 1'b0;
      end else if (advance) begin
        for (int i = 0; i < CNT_W-1; i++) begin
          st_data[i] <= lvl_out[i];
          st_op[i]   <= lvl_op[i];
          st_cnt[i]  <= lvl_cnt[i];
          st_sign[i] <= lvl_sign[i];
        end
        st_valid[0] <= in_valid;
        for (int i = 1; i < CNT_W-1; i++) begin
          st_valid[i] <= st_valid[i-1];
        end
        out_valid_q <= st_valid[CNT_W-2];
        out_data_q  <= lvl_out[CNT_W-1];
        out_zero_q  <= (lvl_out[CNT_W-1] == '0);
      end
    end
  end else begin : g_flat
    for (genvar k = 0; k < CNT_W; k++) begin : g_feed
      if (k == 0) begin : g_first
        assign lvl_in[k] = in_data;
      end else begin : g_rest
        assign lvl_in[k] = lvl_out[k-1];
      end
      assign lvl_op[k]   = in_op;
      assign lvl_cnt[k]  = in_cnt;
      assign lvl_sign[k] = in_data[WIDTH-1];
    end

    // Single output register after the full combinational mux chain.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        out_zero_q  <= 1'b0;
      end else if (advance) begin
        out_valid_q <= in_valid;
        out_data_q  <= lvl_out[CNT_W-1];
        out_zero_q  <= (lvl_out[CNT_W-1] == '0);
      end
    end
  end

endmodule
